// File: rtl/masked_seq_scan_ctrl_if.sv
// Config/control/bit-source/status bundle for the masked serial-pattern scan controller.
interface masked_seq_scan_ctrl_if #(
   parameter int unsigned LEN   = 9,
   parameter int unsigned CNT_W = 8,
   parameter int unsigned WIN_W = 16
);
   logic             cfg_valid;
   logic             cfg_ready;
   logic [LEN-1:0]   cfg_pattern;
   logic [LEN-1:0]   cfg_mask;
   logic [CNT_W-1:0] cfg_limit;
   logic [WIN_W-1:0] cfg_window;
   logic             start;
   logic             abort;
   logic             bit_valid;
   logic             a;
   logic             busy;
   logic             match;
   logic [CNT_W-1:0] match_cnt;
   logic             done;
   logic             timeout;

   modport master (
      output cfg_valid, cfg_pattern, cfg_mask, cfg_limit, cfg_window,
      output start, abort, bit_valid, a,
      input  cfg_ready, busy, match, match_cnt, done, timeout
   );

   modport slave (
      input  cfg_valid, cfg_pattern, cfg_mask, cfg_limit, cfg_window,
      input  start, abort, bit_valid, a,
      output cfg_ready, busy, match, match_cnt, done, timeout
   );
endinterface

// File: rtl/masked_seq_scan_ctrl.sv
// Run controller for the masked serial-pattern detector: config latch, window fill,
// masked compare on every accepted bit, match counting and limit/window/abort termination.
module masked_seq_scan_ctrl #(
   parameter int unsigned LEN   = 9,
   parameter int unsigned CNT_W = 8,
   parameter int unsigned WIN_W = 16
) (
   input logic                  clk,
   input logic                  rst_n,
   masked_seq_scan_ctrl_if.slave bus
);
   localparam int unsigned FILL_W = $clog2(LEN + 1);

   typedef enum logic [1:0] {S_IDLE, S_FILL, S_RUN, S_DONE} state_t;

   state_t           state, state_nxt;
   logic [LEN-1:0]   pattern, mask, sreg, sreg_nxt;
   logic [CNT_W-1:0] limit, match_cnt, cnt_nxt;
   logic [WIN_W-1:0] window, beat_cnt, beat_nxt;
   logic [FILL_W-1:0] fill_cnt;
   logic             match_q, timeout_q;
   logic             active, shift_en, full, hit, lim_stop, win_stop, cfg_acc, start_acc;

   always_comb begin
      active    = (state == S_FILL) || (state == S_RUN);
      cfg_acc   = (state == S_IDLE) && bus.cfg_valid;
      start_acc = (state == S_IDLE) && bus.start;
      shift_en  = active && bus.bit_valid && !bus.abort;
      sreg_nxt  = {sreg[LEN-2:0], bus.a};
      // The shift that delivers the LEN-th bit is the first one compared.
      full      = (state == S_RUN) || (fill_cnt == FILL_W'(LEN - 1));
      hit       = shift_en && full && (((sreg_nxt ^ pattern) & mask) == '0);
      cnt_nxt   = (hit && (match_cnt != '1)) ? match_cnt + CNT_W'(1) : match_cnt;
      beat_nxt  = beat_cnt + WIN_W'(1);
      lim_stop  = shift_en && (limit != '0) && (cnt_nxt == limit);
      win_stop  = shift_en && (window != '0) && (beat_nxt == window) && !lim_stop;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: if (bus.start) state_nxt = S_FILL;
         S_FILL, S_RUN: begin
            if (bus.abort)              state_nxt = S_IDLE;
            else if (lim_stop || win_stop) state_nxt = S_DONE;
            else if (shift_en && full)  state_nxt = S_RUN;
         end
         S_DONE: state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         pattern   <= '0;
         mask      <= '0;
         limit     <= '0;
         window    <= '0;
         sreg      <= '0;
         fill_cnt  <= '0;
         beat_cnt  <= '0;
         match_cnt <= '0;
         match_q   <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state   <= state_nxt;
         match_q <= hit;
         if (cfg_acc) begin
            pattern <= bus.cfg_pattern;
            mask    <= bus.cfg_mask;
            limit   <= bus.cfg_limit;
            window  <= bus.cfg_window;
         end
         if (start_acc) begin
            sreg      <= '0;
            fill_cnt  <= '0;
            beat_cnt  <= '0;
            match_cnt <= '0;
            timeout_q <= 1'b0;
         end else if (active && bus.abort) begin
            timeout_q <= 1'b0;
         end else if (shift_en) begin
            sreg      <= sreg_nxt;
            beat_cnt  <= beat_nxt;
            match_cnt <= cnt_nxt;
            if (state == S_FILL) fill_cnt <= fill_cnt + FILL_W'(1);
            if (win_stop) timeout_q <= 1'b1;
         end
      end
   end

   assign bus.cfg_ready = (state == S_IDLE);
   assign bus.busy      = active;
   assign bus.done      = (state == S_DONE);
   assign bus.match     = match_q;
   assign bus.match_cnt = match_cnt;
   assign bus.timeout   = timeout_q;
endmodule

// File: tb/tb_masked_seq_scan_ctrl.sv
// Self-checking bench: queue-based reference of the scan rules, directed scenarios with
// literal expectations, then a randomized soak compared every cycle.
module tb_masked_seq_scan_ctrl;
   localparam int LEN   = 9;
   localparam int CNT_W = 8;
   localparam int WIN_W = 16;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   masked_seq_scan_ctrl_if #(.LEN(LEN), .CNT_W(CNT_W), .WIN_W(WIN_W)) bus ();

   masked_seq_scan_ctrl #(.LEN(LEN), .CNT_W(CNT_W), .WIN_W(WIN_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   // Reference model: scan is active/done/idle, accepted bits kept in a queue.
   bit           m_active, m_done, e_match, m_timeout;
   int           m_cnt, m_beats, m_lim, m_win;
   bit [LEN-1:0] m_pat, m_mask;
   bit           hist[$];

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_active = 0; m_done = 0; e_match = 0; m_timeout = 0;
         m_cnt = 0; m_beats = 0; m_lim = 0; m_win = 0; m_pat = '0; m_mask = '0;
         hist.delete();
      end else begin
         e_match = 0;
         if (m_done) begin
            m_done = 0;
         end else if (!m_active) begin
            if (bus.cfg_valid) begin
               m_pat = bus.cfg_pattern; m_mask = bus.cfg_mask;
               m_lim = int'(bus.cfg_limit); m_win = int'(bus.cfg_window);
            end
            if (bus.start) begin
               m_active = 1; hist.delete(); m_cnt = 0; m_beats = 0; m_timeout = 0;
            end
         end else if (bus.abort) begin
            m_active = 0; m_timeout = 0;
         end else if (bus.bit_valid) begin
            bit ok;
            hist.push_back(bus.a);
            if (hist.size() > LEN) void'(hist.pop_front());
            m_beats++;
            if (hist.size() == LEN) begin
               ok = 1;
               for (int k = 0; k < LEN; k++)
                  if (m_mask[k] && (hist[LEN-1-k] != m_pat[k])) ok = 0;
               if (ok) begin
                  e_match = 1;
                  if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
               end
            end
            if (m_lim != 0 && m_cnt == m_lim) begin
               m_active = 0; m_done = 1;
            end else if (m_win != 0 && (m_beats % (1 << WIN_W)) == m_win) begin
               m_active = 0; m_done = 1; m_timeout = 1;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         chk("m_cfg_ready", 32'(bus.cfg_ready), 32'(!m_active && !m_done));
         chk("m_busy",      32'(bus.busy),      32'(m_active));
         chk("m_done",      32'(bus.done),      32'(m_done));
         chk("m_match",     32'(bus.match),     32'(e_match));
         chk("m_match_cnt", 32'(bus.match_cnt), 32'(m_cnt));
         chk("m_timeout",   32'(bus.timeout),   32'(m_timeout));
      end
   end

   localparam logic [LEN-1:0] PAT = 9'b011000110;
   localparam logic [LEN-1:0] MSK = 9'b111000111;
   localparam logic [LEN-1:0] SEQ = 9'b011101110; // sent MSB first; matches PAT under MSK

   task automatic idle_inputs();
      bus.cfg_valid = 0; bus.start = 0; bus.abort = 0; bus.bit_valid = 0; bus.a = 0;
   endtask

   task automatic gap();
      @(negedge clk);
   endtask

   task automatic beat(input logic b);
      bus.bit_valid = 1; bus.a = b;
      @(negedge clk);
      bus.bit_valid = 0;
   endtask

   task automatic cfg_start(input logic [LEN-1:0] p, input logic [LEN-1:0] m,
                            input logic [CNT_W-1:0] l, input logic [WIN_W-1:0] w);
      bus.cfg_valid = 1; bus.cfg_pattern = p; bus.cfg_mask = m;
      bus.cfg_limit = l; bus.cfg_window = w; bus.start = 1;
      @(negedge clk);
      bus.cfg_valid = 0; bus.start = 0;
   endtask

   task automatic do_abort(input logic with_bit);
      bus.abort = 1; bus.bit_valid = with_bit; bus.a = 1'b0;
      @(negedge clk);
      bus.abort = 0; bus.bit_valid = 0;
   endtask

   logic [LEN-1:0] seq;

   initial begin
      idle_inputs();
      bus.cfg_pattern = '0; bus.cfg_mask = '0; bus.cfg_limit = '0; bus.cfg_window = '0;
      seq = SEQ;
      #12;
      chk("rst_cfg_ready", 32'(bus.cfg_ready), 32'd1);
      chk("rst_busy",      32'(bus.busy),      32'd0);
      chk("rst_match_cnt", 32'(bus.match_cnt), 32'd0);
      chk("rst_timeout",   32'(bus.timeout),   32'd0);
      @(negedge clk); rst_n = 1; @(negedge clk);

      // basic match
      cfg_start(PAT, MSK, 0, 0);
      for (int i = LEN - 1; i >= 1; i--) beat(seq[i]);
      chk("basic_fill_nomatch", 32'(bus.match), 32'd0);
      beat(seq[0]);
      chk("basic_match", 32'(bus.match), 32'd1);
      chk("basic_cnt",   32'(bus.match_cnt), 32'd1);
      chk("basic_busy",  32'(bus.busy), 32'd1);
      gap();
      chk("basic_pulse_end", 32'(bus.match), 32'd0);
      do_abort(0);

      // limit stop with gaps
      cfg_start(PAT, MSK, 2, 0);
      for (int r = 0; r < 2; r++)
         for (int i = LEN - 1; i >= 0; i--) begin
            beat(seq[i]);
            if (!(r == 1 && i == 0)) gap();
         end
      chk("lim_match",   32'(bus.match), 32'd1);
      chk("lim_done",    32'(bus.done), 32'd1);
      chk("lim_timeout", 32'(bus.timeout), 32'd0);
      chk("lim_cnt",     32'(bus.match_cnt), 32'd2);
      gap();
      chk("lim_ready_after", 32'(bus.cfg_ready), 32'd1);

      // window timeout, then match on the final beat
      cfg_start(PAT, MSK, 1, 12);
      for (int i = 0; i < 12; i++) beat(1'b0);
      chk("win_done",    32'(bus.done), 32'd1);
      chk("win_timeout", 32'(bus.timeout), 32'd1);
      chk("win_cnt",     32'(bus.match_cnt), 32'd0);
      gap();
      cfg_start(PAT, MSK, 1, 12);
      for (int i = 0; i < 3; i++) beat(1'b0);
      for (int i = LEN - 1; i >= 0; i--) beat(seq[i]);
      chk("winlim_done",    32'(bus.done), 32'd1);
      chk("winlim_timeout", 32'(bus.timeout), 32'd0);
      chk("winlim_cnt",     32'(bus.match_cnt), 32'd1);
      gap();

      // overlap with all don't-care
      cfg_start('0, '0, 0, 0);
      for (int i = 0; i < 8; i++) beat(1'($urandom_range(0, 1)));
      chk("ovl_fill_cnt", 32'(bus.match_cnt), 32'd0);
      for (int i = 0; i < 3; i++) begin
         beat(1'($urandom_range(0, 1)));
         chk("ovl_match", 32'(bus.match), 32'd1);
      end
      chk("ovl_cnt", 32'(bus.match_cnt), 32'd3);

      // cfg and start ignored while running
      bus.cfg_valid = 1; bus.cfg_pattern = '1; bus.cfg_mask = '1; bus.cfg_limit = 1;
      bus.start = 1;
      #1 chk("run_cfg_ready", 32'(bus.cfg_ready), 32'd0);
      @(negedge clk);
      idle_inputs();
      chk("run_start_ign_cnt", 32'(bus.match_cnt), 32'd3);
      beat(1'b0);
      chk("run_cfg_ign_match", 32'(bus.match), 32'd1);
      chk("run_cfg_ign_cnt",   32'(bus.match_cnt), 32'd4);
      do_abort(1);
      chk("abort_busy",  32'(bus.busy), 32'd0);
      chk("abort_match", 32'(bus.match), 32'd0);
      chk("abort_cnt",   32'(bus.match_cnt), 32'd4);

      // abort on a would-be matching 9th beat
      cfg_start(PAT, MSK, 0, 0);
      for (int i = LEN - 1; i >= 1; i--) beat(seq[i]);
      bus.a = seq[0]; bus.bit_valid = 1; bus.abort = 1;
      @(negedge clk);
      idle_inputs();
      chk("ab9_match", 32'(bus.match), 32'd0);
      chk("ab9_done",  32'(bus.done), 32'd0);
      chk("ab9_ready", 32'(bus.cfg_ready), 32'd1);
      chk("ab9_cnt",   32'(bus.match_cnt), 32'd0);

      // asynchronous reset mid-scan
      cfg_start('0, '0, 0, 0);
      for (int i = 0; i < 11; i++) beat(1'b1);
      chk("rs_cnt_before", 32'(bus.match_cnt), 32'd3);
      #3 rst_n = 0;
      #1;
      chk("rs_cnt",   32'(bus.match_cnt), 32'd0);
      chk("rs_busy",  32'(bus.busy), 32'd0);
      chk("rs_match", 32'(bus.match), 32'd0);
      chk("rs_ready", 32'(bus.cfg_ready), 32'd1);
      @(negedge clk); rst_n = 1;
      seq = 9'b101010101;
      cfg_start(seq, '1, 0, 0);
      for (int i = LEN - 1; i >= 0; i--) beat(seq[i]);
      chk("rs_new_match", 32'(bus.match), 32'd1);
      chk("rs_new_cnt",   32'(bus.match_cnt), 32'd1);
      do_abort(0);

      // randomized soak, checked every cycle against the model
      for (int c = 0; c < 4000; c++) begin
         bus.start       = ($urandom_range(0, 7) == 0);
         bus.cfg_valid   = ($urandom_range(0, 2) == 0);
         bus.cfg_pattern = LEN'($urandom);
         bus.cfg_mask    = LEN'($urandom & $urandom & $urandom);
         bus.cfg_limit   = CNT_W'($urandom_range(0, 3));
         bus.cfg_window  = ($urandom_range(0, 3) == 0) ? '0 : WIN_W'($urandom_range(1, 40));
         bus.abort       = ($urandom_range(0, 49) == 0);
         bus.bit_valid   = ($urandom_range(0, 3) != 0);
         bus.a           = 1'($urandom_range(0, 1));
         @(negedge clk);
      end
      idle_inputs();
      repeat (3) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
